// File: rtl/wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
//   wb_params_t    : one register-file write (destination address + data)
//   wb_arb_state_t : arbiter FSM state (pipeline priority / forced drain)
//   wb_arb_entry_t : MCU result FIFO entry; live=0 marks a WAW-killed result
package wb_arbiter_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_data;
    } wb_params_t;

    typedef enum logic {
        WB_ARB_PIPE  = 1'b0,
        WB_ARB_DRAIN = 1'b1
    } wb_arb_state_t;

    typedef struct packed {
        wb_params_t params;
        logic       live;
    } wb_arb_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// MCU result FIFO for wb_arbiter.
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push/push_entry : write one entry at the tail (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   kill/kill_addr  : clear live on every stored entry whose rd_addr matches;
//                     the entry pushed in the same cycle is never killed
//   head            : current head entry
//   count/full/empty: occupancy
import wb_arbiter_pkg::*;

module wb_arb_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_arb_entry_t              push_entry,
    input  logic                       pop,
    input  logic                       kill,
    input  logic [ADDR_W-1:0]          kill_addr,
    output wb_arb_entry_t              head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_arb_entry_t   mem_q [DEPTH];
    wb_arb_entry_t   mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        // Kill is applied to stored slots first, so the slot written by a
        // simultaneous push keeps its live bit.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill && mem_q[i].params.rd_addr == kill_addr) begin
                mem_d[i].live = 1'b0;
            end
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
        end
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count=0 makes every slot unreachable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between the pipeline WB stage and
// buffered multi-cycle-unit (MCU) completions.
//   clk, rst              : clock, synchronous active-high reset
//   wb_valid, wb_params   : pipeline write request (re-presented while stalled)
//   mcu_valid, mcu_params : MCU result; accepted when mcu_ready
//   mcu_ready             : FIFO not full
//   stall                 : freezes the pipeline while the FIFO drains
//   rf_we/rf_waddr/rf_wdata : write port (address/data are 0 when rf_we=0)
//   pending               : FIFO non-empty
// Optional macro WB_ARB_STARVE_EN: adds the starve counter that forces a
// drain after a live head has waited STARVE_LIMIT cycles.
import wb_arbiter_pkg::*;

module wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  wb_params_t        wb_params,
    input  logic              mcu_valid,
    input  wb_params_t        mcu_params,
    output logic              mcu_ready,
    output logic              stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pending
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
        $error("wb_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    wb_arb_state_t state_q, state_d;
    wb_arb_entry_t head, push_entry;
    logic [CW-1:0] count, count_next;
    logic          full, empty;
    logic          push, pop, kill;
    logic          starve_hit;

    wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill       (kill),
        .kill_addr  (wb_params.rd_addr),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        push_entry = '{params: mcu_params, live: 1'b1};
        mcu_ready  = !rst && !full;
        pending    = !rst && !empty;
        push       = mcu_valid && mcu_ready;
        stall      = 1'b0;
        pop        = 1'b0;
        kill       = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        if (!rst) begin
            if (state_q == WB_ARB_DRAIN) begin
                stall = 1'b1;
                pop   = !empty;
                if (!empty && head.live) begin
                    rf_we    = 1'b1;
                    rf_waddr = head.params.rd_addr;
                    rf_wdata = head.params.rd_data;
                end
            end else begin
                kill = wb_valid;
                if (wb_valid) begin
                    rf_we    = 1'b1;
                    rf_waddr = wb_params.rd_addr;
                    rf_wdata = wb_params.rd_data;
                end else if (!empty && head.live) begin
                    rf_we    = 1'b1;
                    rf_waddr = head.params.rd_addr;
                    rf_wdata = head.params.rd_data;
                end
                // Dead heads never need the port, so they are dropped at once.
                pop = !empty && (!head.live || !wb_valid);
            end
        end
        count_next = count + CW'(push) - CW'(pop);
    end

`ifdef WB_ARB_STARVE_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (head.live && starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
        starve_hit = (starve_d == SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_ARB_PIPE: begin
                if (count_next == CW'(DEPTH) || starve_hit) begin
                    state_d = WB_ARB_DRAIN;
                end
            end
            WB_ARB_DRAIN: begin
                if (count_next == '0) begin
                    state_d = WB_ARB_PIPE;
                end
            end
            default: state_d = WB_ARB_PIPE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_ARB_PIPE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a queue-based reference model.
import wb_arbiter_pkg::*;

module tb_wb_arbiter;

    localparam int unsigned DEPTH        = 4;
    localparam int unsigned STARVE_LIMIT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wb_valid = 1'b0;
    wb_params_t        wb_params = '0;
    logic              mcu_valid = 1'b0;
    wb_params_t        mcu_params = '0;
    logic              mcu_ready, stall, rf_we, pending;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_params  (wb_params),
        .mcu_valid  (mcu_valid),
        .mcu_params (mcu_params),
        .mcu_ready  (mcu_ready),
        .stall      (stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .pending    (pending)
    );

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bit                live;
    } m_ent_t;

    m_ent_t            mq[$];
    bit                m_drain  = 1'b0;
    int unsigned       m_starve = 0;
    logic [DATA_W-1:0] dut_rf [32];
    int                n_assert = 0;
    int                n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model,
    // then advance the model across the clock edge.
    task automatic step(input logic r, input logic wv, input logic [ADDR_W-1:0] wa,
                        input logic [DATA_W-1:0] wd, input logic mv,
                        input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md);
        bit                exp_we = 1'b0;
        logic [ADDR_W-1:0] exp_a  = '0;
        logic [DATA_W-1:0] exp_d  = '0;
        bit                popf   = 1'b0;
        bit                was_empty, head_live, do_push;
        int unsigned       sz;

        rst       = r;
        wb_valid  = wv;
        wb_params = '{rd_addr: wa, rd_data: wd};
        mcu_valid = mv;
        mcu_params = '{rd_addr: ma, rd_data: md};
        #2;

        sz = mq.size();
        if (!r) begin
            if (m_drain) begin
                if (sz > 0) begin
                    popf = 1'b1;
                    if (mq[0].live) begin
                        exp_we = 1'b1; exp_a = mq[0].a; exp_d = mq[0].d;
                    end
                end
            end else begin
                if (wv) begin
                    exp_we = 1'b1; exp_a = wa; exp_d = wd;
                end
                if (sz > 0 && (!mq[0].live || !wv)) begin
                    popf = 1'b1;
                    if (mq[0].live) begin
                        exp_we = 1'b1; exp_a = mq[0].a; exp_d = mq[0].d;
                    end
                end
            end
        end

        chk("rf_we",     32'(rf_we),     32'(exp_we));
        chk("rf_waddr",  32'(rf_waddr),  32'(exp_a));
        chk("rf_wdata",  rf_wdata,       exp_d);
        chk("stall",     32'(stall),     32'(!r && m_drain));
        chk("mcu_ready", 32'(mcu_ready), 32'(!r && sz < DEPTH));
        chk("pending",   32'(pending),   32'(!r && sz > 0));

        if (rf_we === 1'b1) dut_rf[rf_waddr] = rf_wdata;

        if (r) begin
            mq.delete();
            m_drain  = 1'b0;
            m_starve = 0;
        end else begin
            was_empty = (sz == 0);
            head_live = (sz > 0) && mq[0].live;
            do_push   = mv && (sz < DEPTH);
            if (popf) void'(mq.pop_front());
            if (wv && !m_drain) begin
                foreach (mq[i]) if (mq[i].a == wa) mq[i].live = 1'b0;
            end
            if (do_push) mq.push_back('{a: ma, d: md, live: 1'b1});
            if (popf || was_empty) m_starve = 0;
            else if (head_live && m_starve < STARVE_LIMIT) m_starve++;
            if (!m_drain) begin
                if (mq.size() == DEPTH) m_drain = 1'b1;
`ifdef WB_ARB_STARVE_EN
                if (m_starve == STARVE_LIMIT) m_drain = 1'b1;
`endif
            end else if (mq.size() == 0) begin
                m_drain = 1'b0;
            end
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    endtask

    initial begin
        foreach (dut_rf[i]) dut_rf[i] = '0;
        @(posedge clk);
        #1;

        // Reset values, including active inputs while rst=1.
        do_reset();

        // Single MCU push, written on the next idle WB cycle.
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 32'h11);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(1);
        chk("r3_value", dut_rf[3], 32'h11);

        // Fill under continuous wb_valid -> forced drain.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 5'(10 + i), 32'(100 + i), 1'b1, 5'(20 + i), 32'(200 + i));
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 5'd14, 32'h0E, 1'b0, '0, '0);
        chk("r23_value", dut_rf[23], 32'd203);

        // WAW kill: older MCU result for r5 must not land after the pipeline write.
        do_reset();
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 32'hAA);
        step(1'b0, 1'b1, 5'd5, 32'hBB, 1'b0, '0, '0);
        idle(3);
        chk("r5_value", dut_rf[5], 32'hBB);

`ifdef WB_ARB_STARVE_EN
        // Starvation: live head behind continuous pipeline writes.
        do_reset();
        step(1'b0, 1'b1, 5'd1, 32'h01, 1'b1, 5'd9, 32'h99);
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b1, 5'd2, 32'(i), 1'b0, '0, '0);
        chk("r9_value", dut_rf[9], 32'h99);
`endif

        // Reset in the middle of a drain with three entries left.
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 5'(10 + i), 32'(i), 1'b1, 5'(24 + i), 32'(300 + i));
        step(1'b0, 1'b1, 5'd13, 32'h3, 1'b0, '0, '0);
        step(1'b1, 1'b1, 5'd13, 32'h3, 1'b0, '0, '0);
        idle(3);
        chk("r25_dropped", dut_rf[25], 32'h0);

        // Same-cycle push and pipeline write to r7: MCU value lands last.
        step(1'b0, 1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 32'h33);
        chk("r7_first", dut_rf[7], 32'h22);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("r7_last", dut_rf[7], 32'h33);

        // Random traffic on a small address range to provoke kills.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Arbiter for the single register-file write port, shared between the in-order pipeline WB stage (fed by the MEM/WB register) and out-of-order completions from a multi-cycle unit (MCU: divider, long-latency loads). MCU results are buffered in a small FIFO and written on idle WB cycles. When the FIFO fills or its head starves, the block stalls the pipeline and drains the FIFO. It also enforces write-after-write ordering so that a later pipeline write is never overwritten by an older buffered MCU result.

## Interface
- `DEPTH`, 4: MCU result FIFO entries; power of two, ≥2.
- `STARVE_LIMIT`, 8: consecutive cycles a live FIFO head may wait before a forced drain.

- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `wb_valid` in 1: pipeline WB write request this cycle.
- `wb_params` in `wb_params_t`: pipeline destination (`rd_addr`, `rd_data`).
- `mcu_valid` in 1: MCU result available.
- `mcu_params` in `wb_params_t`: MCU destination and data.
- `mcu_ready` out 1: FIFO accepts an MCU result; equals `!full`.
- `stall` out 1: freezes the pipeline, including MEM/WB; the held WB request is re-presented.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out `rd_addr` width: write address.
- `rf_wdata` out `rd_data` width: write data.
- `pending` out 1: FIFO non-empty.

## Operation
- **FIFO.** Entries are `{params, live}`. A push occurs when `mcu_valid && mcu_ready`; pushed entries are live. There is no push when full, even if a pop occurs in the same cycle.
- **FSM state PIPE (reset state).**
  - `stall=0`.
  - When `wb_valid=1`, the port writes `wb_params`.
  - When `wb_valid=0` and the head is live, the port writes the head and pops it.
  - A dead head is popped in any cycle with `rf_we` unaffected by it.
- **FSM state DRAIN.**
  - `stall=1`. `wb_valid` is ignored.
  - One pop per cycle; a live head is written, a dead head is popped silently.
  - Pushes are still accepted.
- **Transitions.**
  - PIPE→DRAIN at the edge where next-count == `DEPTH`, or where the starve counter reaches `STARVE_LIMIT`.
  - DRAIN→PIPE at the edge where next-count == 0.
- **WAW kill.** A committed pipeline write (`wb_valid && !stall`) clears `live` on every FIFO entry whose `rd_addr` matches. An entry being pushed in the same cycle is not killed, because MCU completion is architecturally newer.
- **Starve counter.** Increments each cycle the head is live and not popped. Clears on pop or when empty. Saturates at `STARVE_LIMIT`.
- **Width.** Count is `$clog2(DEPTH)+1` bits. Pointers are `$clog2(DEPTH)` bits and wrap naturally.
- **Outputs.**
  - `rf_waddr`/`rf_wdata` are 0 whenever `rf_we=0`.
  - `stall`, `mcu_ready`, `pending` and `rf_*` are combinational from the state and inputs.

## Timing
- Pipeline write: 0-cycle; written in the same cycle as `wb_valid` in PIPE.
- MCU write: the earliest write is the cycle after the push. A push to an empty FIFO with `wb_valid=0` in the next cycle writes in that next cycle.
- `stall` rises the cycle after the triggering edge and falls the cycle after the last pop.
- **Reset (any state, mid-drain included).**
  - FIFO emptied, FSM=PIPE, starve counter 0.
  - While `rst=1`: `rf_we=0`, `stall=0`, `mcu_ready=0`, `pending=0`.
  - In-flight FIFO contents are discarded.

## Configuration
- `WB_ARB_STARVE_EN` defined: the starve counter and the starvation transition are compiled in.
- Not defined: there is no counter, and DRAIN is entered only on full. A live head may wait indefinitely under continuous `wb_valid`. `STARVE_LIMIT` is unused.

## Structure
- `types` package gains:
  - `wb_arb_state_t` (`WB_ARB_PIPE`, `WB_ARB_DRAIN`).
  - `wb_arb_entry_t` (`wb_params_t params; logic live`).
- One sub-module, `wb_arb_fifo`, holds the storage, pointers and count, and provides a parallel `rd_addr` kill port. FSM, port mux and starve counter stay in `wb_arbiter`.

## Test plan
- Push `{r3, 0x11}` with `wb_valid=0` -> `rf_we=1`, `rf_waddr=3`, `rf_wdata=0x11` the next cycle; `pending` then 0.
- Continuous `wb_valid`, 4 MCU pushes (`DEPTH=4`) -> `mcu_ready=0`, `stall=1` the next cycle, 4 write cycles, then `stall=0`.
- Push `{r5, 0xAA}`, then pipeline write `{r5, 0xBB}` -> the entry is killed; r5 final value is 0xBB; the dead pop produces no write.
- With `WB_ARB_STARVE_EN` and `STARVE_LIMIT=8`: one push plus continuous `wb_valid` -> `stall` asserts after 8 waiting cycles, one MCU write, release.
- Assert `rst` during DRAIN with 3 entries -> the next cycle `stall=0` and `pending=0`, with no `rf_we` during or after reset.
- Push and pipeline write to the same `rd_addr` in the same cycle -> the pipeline writes first, the MCU entry survives, and the MCU value is written last.
